// File: rtl/token_pkg.sv
// +--------------------------------------------------------------------+
// | token_pkg : shared FSM state type and count-width helper           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package token_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // Bits needed to hold a count of 0..window inclusive.
    function automatic int cnt_w(input int window);
        return $clog2(window + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/token_fifo.sv
// +--------------------------------------------------------------------+
// | token_fifo : power-of-two ring buffer, head presented from regs    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module token_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int PW    = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             do_push;
    logic             do_pop;

    assign full     = (occ == OCC_W'(DEPTH));
    assign empty    = (occ == '0);
    assign do_pop   = pop && !empty;
    // A full buffer still takes a push when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                occ <= occ + 1'b1;
            end else if (do_pop && !do_push) begin
                occ <= occ - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/token_window_counter.sv
// +--------------------------------------------------------------------+
// | token_window_counter : counts tokens over fixed windows into FIFO  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module token_window_counter
    import token_pkg::*;
#(
    parameter int WINDOW = 8,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tok,
    input  logic                       start,
    input  logic                       cont,
    output logic [cnt_w(WINDOW)-1:0]   cnt_data,
    output logic                       cnt_valid,
    input  logic                       cnt_ready,
    output logic                       dropped,
    output logic                       busy
);

    localparam int CW = cnt_w(WINDOW);
    localparam int WW = $clog2(WINDOW);

    state_t          state;
    logic [WW-1:0]   wcnt;
    logic [CW-1:0]   acc;
    logic            last;
    logic            push;
    logic [CW-1:0]   push_data;
    logic            pop;
    logic            full;
    logic            empty;

    assign last      = (state == COUNT) && (wcnt == WW'(WINDOW - 1));
    assign push      = last;
    // The final sample joins the count in the same cycle it is pushed.
    assign push_data = acc + CW'(tok);
    assign cnt_valid = !empty;
    assign pop       = cnt_valid && cnt_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            wcnt  <= '0;
            acc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= COUNT;
                        busy  <= 1'b1;
                        wcnt  <= '0;
                        acc   <= '0;
                    end
                end
                COUNT: begin
                    if (last) begin
                        wcnt <= '0;
                        acc  <= '0;
                        if (!cont) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        wcnt <= wcnt + 1'b1;
                        acc  <= acc + CW'(tok);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dropped <= 1'b0;
        end else if (push && full && !pop) begin
            dropped <= 1'b1;
        end
    end

    token_fifo #(
        .W     (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (cnt_data),
        .full      (full),
        .empty     (empty)
    );

endmodule

`default_nettype wire
